uart_mem_engine: RTL and testbench

UART_MEM_ENGINE -- requirements
Module: uart_mem_engine

---
 rtl/uart_mem_engine_if.sv | 38 +++
 rtl/uart_mem_engine.sv | 139 +++++++++++++
 tb/tb_uart_mem_engine.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_engine_if.sv
// rtl/uart_mem_engine_if.sv - command, UART and memory signal bundle for uart_mem_engine
interface uart_mem_engine_if #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              exec_valid;
    logic [ADDR_W-1:0] exec_addr;
    logic              done;

    // host / UART / memory side
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, rx_valid, rx_byte, tx_busy, mem_rdata,
        input  cmd_ready, tx_start, tx_byte, mem_addr, mem_wdata, mem_we, mem_re,
               exec_valid, exec_addr, done
    );

    // engine side
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, rx_valid, rx_byte, tx_busy, mem_rdata,
        output cmd_ready, tx_start, tx_byte, mem_addr, mem_wdata, mem_we, mem_re,
               exec_valid, exec_addr, done
    );
endinterface

// File: rtl/uart_mem_engine.sv
// rtl/uart_mem_engine.sv - UART-driven memory load/dump/exec command engine
module uart_mem_engine #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_mem_engine_if.slave bus
);
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_DUMP = 2'd2;
    localparam logic [1:0] OP_EXEC = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RD, S_RDW, S_TX, S_TXH, S_TXW, S_FIN
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [LEN_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              we;
    logic [7:0]        tx_byte_q;
    logic              exec_q;
    logic [ADDR_W-1:0] exec_addr_q;
    logic              accept;
    logic              rx_take;
    logic              step;
    logic [LEN_W-1:0]  cnt_dec;

    assign accept  = (state == S_IDLE) && bus.cmd_valid;
    assign rx_take = (state == S_LOAD) && bus.rx_valid;
    // saturating decrement: the counter never wraps below zero
    assign cnt_dec = (cnt != '0) ? cnt - LEN_W'(1) : cnt;

    // one byte finished: received in LOAD, or UART free again after a send in TXW
    assign step = rx_take || ((state == S_TXW) && !bus.tx_busy);

    // next-state and address/count sequencing
    always_comb begin
        state_next = state;
        addr_next  = addr;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_next = bus.cmd_addr;
                    cnt_next  = bus.cmd_len;
                    if (bus.cmd_len != '0 && bus.cmd_op == OP_LOAD) begin
                        state_next = S_LOAD;
                    end else if (bus.cmd_len != '0 && bus.cmd_op == OP_DUMP) begin
                        state_next = S_RD;
                    end else begin
                        state_next = S_FIN;
                    end
                end
            end
            S_LOAD, S_TXW: begin
                if (step) begin
                    addr_next = addr + ADDR_W'(1);
                    cnt_next  = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_next = S_FIN;
                    end else if (state == S_TXW) begin
                        state_next = S_RD;
                    end
                end
            end
            S_RD:    state_next = S_RDW;
            S_RDW:   state_next = S_TX;
            S_TX:    state_next = S_TXH;
            S_TXH:   state_next = S_TXW;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // state, working address and remaining count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            addr  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            cnt   <= cnt_next;
        end
    end

    // write strobe lands the cycle after each accepted received byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= rx_take;
            if (rx_take) begin
                waddr <= addr;
                wdata <= bus.rx_byte;
            end
        end
    end

    // read data is valid in RDW; hold it as the transmit byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte_q <= '0;
        end else if (state == S_RDW) begin
            tx_byte_q <= bus.mem_rdata;
        end
    end

    // jump request issued in the FIN cycle that follows an EXEC accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q      <= 1'b0;
            exec_addr_q <= '0;
        end else begin
            exec_q <= accept && (bus.cmd_op == OP_EXEC);
            if (accept && (bus.cmd_op == OP_EXEC)) begin
                exec_addr_q <= bus.cmd_addr;
            end
        end
    end

    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.mem_re     = (state == S_RD);
    assign bus.mem_we     = we;
    assign bus.mem_addr   = (state == S_RD) ? addr : waddr;
    assign bus.mem_wdata  = wdata;
    assign bus.tx_start   = (state == S_TX);
    assign bus.tx_byte    = tx_byte_q;
    assign bus.exec_valid = exec_q;
    assign bus.exec_addr  = exec_addr_q;
    assign bus.done       = (state == S_FIN);
endmodule

// File: tb/tb_uart_mem_engine.sv
// tb/tb_uart_mem_engine.sv - self-checking bench for uart_mem_engine
module tb_uart_mem_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    uart_mem_engine_if #(.ADDR_W(16), .LEN_W(6)) bus ();
    uart_mem_engine #(.ADDR_W(16), .LEN_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [65536];
    int busy_len = 0;
    int busy_cnt = 0;

    // memory read port: data the cycle after the read strobe
    always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];

    // UART transmitter: busy for busy_len cycles after each start
    always @(posedge clk) begin
        if (bus.tx_start && busy_len > 0) begin
            busy_cnt    <= busy_len;
            bus.tx_busy <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt    <= 0;
            bus.tx_busy <= 1'b0;
        end
    end

    logic [23:0] wr_q[$];
    logic [15:0] rd_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc[$];
    logic [15:0] ex_q[$];
    int          done_cnt = 0;
    int          viol = 0;
    logic        p_done = 0, p_re = 0, p_tx = 0, p_ex = 0;

    // observe strobes away from the active edge and log them
    always @(negedge clk) begin : mon
        int v;
        v = 0;
        if (rst_n) begin
            if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.mem_re) rd_q.push_back(bus.mem_addr);
            if (bus.tx_start) begin
                tx_q.push_back(bus.tx_byte);
                tx_cyc.push_back(cyc);
                if (bus.tx_busy) v++;
            end
            if (bus.exec_valid) begin
                ex_q.push_back(bus.exec_addr);
                if (!bus.done) v++;
            end
            if (bus.mem_we && bus.mem_re) v++;
            if ((bus.done && p_done) || (bus.mem_re && p_re) ||
                (bus.tx_start && p_tx) || (bus.exec_valid && p_ex)) v++;
            if (bus.done) done_cnt <= done_cnt + 1;
        end
        viol   <= viol + v;
        p_done <= rst_n && bus.done;
        p_re   <= rst_n && bus.mem_re;
        p_tx   <= rst_n && bus.tx_start;
        p_ex   <= rst_n && bus.exec_valid;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] a, input logic [5:0] len);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            step();
            n++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        step();
        bus.rx_valid = 1'b0;
        step();
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt <= d0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt <= d0) check("done_timeout", 32'(done_cnt - d0), 32'd1);
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [15:0]      addr;
        logic [5:0]       len;
        int               nrx;
        logic [2:0][7:0]  d;
        int               busy;
        int               exp_wr;
        int               exp_rd;
        int               exp_tx;
        int               exp_ex;
        logic [2:0][15:0] ea;
        logic [2:0][7:0]  eb;
        int               gap;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] a, input logic [5:0] len,
                                input int nrx, input logic [23:0] d, input int busy,
                                input int ewr, input int erd, input int etx, input int eex,
                                input logic [47:0] ea, input logic [23:0] eb, input int gap);
        vec_t v;
        v.op = op; v.addr = a; v.len = len; v.nrx = nrx; v.d = d; v.busy = busy;
        v.exp_wr = ewr; v.exp_rd = erd; v.exp_tx = etx; v.exp_ex = eex;
        v.ea = ea; v.eb = eb; v.gap = gap;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, t0, e0, d0;
        logic [7:0]  rb[8];
        logic [1:0]  op;
        logic [15:0] a;
        logic [5:0]  len;
        logic [15:0] ai;

        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
        bus.rx_valid = 0; bus.rx_byte = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22;
        mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;

        tbl[0] = mk(2'd1, 16'h1000, 6'd3, 3, {8'hCC, 8'hBB, 8'hAA}, 0, 3, 0, 0, 0,
                    {16'h1002, 16'h1001, 16'h1000}, {8'hCC, 8'hBB, 8'hAA}, 0);
        tbl[1] = mk(2'd2, 16'h0020, 6'd2, 0, 24'h0, 10, 0, 2, 2, 0,
                    {16'h0, 16'h0021, 16'h0020}, {8'h0, 8'h22, 8'h11}, 14);
        tbl[2] = mk(2'd2, 16'hFFFF, 6'd2, 0, 24'h0, 1, 0, 2, 2, 0,
                    {16'h0, 16'h0000, 16'hFFFF}, {8'h0, 8'hA5, 8'h5A}, 5);
        tbl[3] = mk(2'd3, 16'h0400, 6'd5, 0, 24'h0, 0, 0, 0, 0, 1,
                    {32'h0, 16'h0400}, 24'h0, 0);
        tbl[4] = mk(2'd0, 16'h1234, 6'd4, 0, 24'h0, 0, 0, 0, 0, 0, 48'h0, 24'h0, 0);
        tbl[5] = mk(2'd1, 16'h2000, 6'd0, 1, 24'h77, 0, 0, 0, 0, 0, 48'h0, 24'h0, 0);
        tbl[6] = mk(2'd1, 16'hFFFE, 6'd3, 3, {8'h03, 8'h02, 8'h01}, 0, 3, 0, 0, 0,
                    {16'h0000, 16'hFFFF, 16'hFFFE}, {8'h03, 8'h02, 8'h01}, 0);

        // reset state
        step(); step();
        check("rst_strobes", 32'({bus.mem_we, bus.mem_re, bus.tx_start, bus.exec_valid, bus.done}), 32'd0);
        check("rst_data", 32'({bus.mem_addr, bus.mem_wdata, bus.tx_byte}), 32'd0);
        check("rst_exec_addr", 32'(bus.exec_addr), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // directed table
        foreach (tbl[k]) begin
            busy_len = tbl[k].busy;
            w0 = wr_q.size(); r0 = rd_q.size(); t0 = tx_q.size(); e0 = ex_q.size(); d0 = done_cnt;
            send_cmd(tbl[k].op, tbl[k].addr, tbl[k].len);
            for (int i = 0; i < tbl[k].nrx; i++) send_rx(tbl[k].d[i]);
            wait_done(d0, 400);
            step(); step(); step();
            check($sformatf("t%0d_done", k), 32'(done_cnt - d0), 32'd1);
            check($sformatf("t%0d_ready", k), 32'(bus.cmd_ready), 32'd1);
            check($sformatf("t%0d_nwr", k), 32'(wr_q.size() - w0), 32'(tbl[k].exp_wr));
            check($sformatf("t%0d_nrd", k), 32'(rd_q.size() - r0), 32'(tbl[k].exp_rd));
            check($sformatf("t%0d_ntx", k), 32'(tx_q.size() - t0), 32'(tbl[k].exp_tx));
            check($sformatf("t%0d_nex", k), 32'(ex_q.size() - e0), 32'(tbl[k].exp_ex));
            for (int i = 0; i < tbl[k].exp_wr && w0 + i < wr_q.size(); i++)
                check($sformatf("t%0d_wr%0d", k, i), 32'(wr_q[w0+i]), 32'({tbl[k].ea[i], tbl[k].eb[i]}));
            for (int i = 0; i < tbl[k].exp_rd && r0 + i < rd_q.size(); i++)
                check($sformatf("t%0d_rd%0d", k, i), 32'(rd_q[r0+i]), 32'(tbl[k].ea[i]));
            for (int i = 0; i < tbl[k].exp_tx && t0 + i < tx_q.size(); i++)
                check($sformatf("t%0d_tx%0d", k, i), 32'(tx_q[t0+i]), 32'(tbl[k].eb[i]));
            if (tbl[k].gap != 0 && tx_cyc.size() >= t0 + 2)
                check($sformatf("t%0d_gap", k), 32'(tx_cyc[t0+1] - tx_cyc[t0]), 32'(tbl[k].gap));
            if (tbl[k].exp_ex != 0 && ex_q.size() > e0)
                check($sformatf("t%0d_exaddr", k), 32'(ex_q[e0]), 32'(tbl[k].ea[0]));
        end

        // reset after first of three LOAD bytes
        busy_len = 0;
        w0 = wr_q.size(); d0 = done_cnt;
        send_cmd(2'd1, 16'h4000, 6'd3);
        send_rx(8'h5C);
        step();
        rst_n = 1'b0;
        #1;
        check("ar_strobes", 32'({bus.mem_we, bus.mem_re, bus.tx_start, bus.exec_valid, bus.done}), 32'd0);
        check("ar_data", 32'({bus.mem_addr, bus.mem_wdata, bus.tx_byte}), 32'd0);
        check("ar_exec_addr", 32'(bus.exec_addr), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("ar_ready", 32'(bus.cmd_ready), 32'd1);
        send_rx(8'h66);
        send_rx(8'h77);
        check("ar_nwr", 32'(wr_q.size() - w0), 32'd1);
        if (wr_q.size() > w0) check("ar_wr0", 32'(wr_q[w0]), 32'h40005C);
        check("ar_done", 32'(done_cnt - d0), 32'd0);
        send_cmd(2'd1, 16'h5000, 6'd1);
        send_rx(8'h99);
        wait_done(d0, 100);
        check("ar_next_nwr", 32'(wr_q.size() - w0), 32'd2);
        if (wr_q.size() > w0 + 1) check("ar_next_wr", 32'(wr_q[w0+1]), 32'h500099);
        check("ar_next_done", 32'(done_cnt - d0), 32'd1);

        // rx in IDLE, cmd_valid during DUMP
        w0 = wr_q.size(); t0 = tx_q.size(); d0 = done_cnt;
        send_rx(8'h12); send_rx(8'h34); send_rx(8'h56);
        check("idle_rx_nwr", 32'(wr_q.size() - w0), 32'd0);
        check("idle_rx_done", 32'(done_cnt - d0), 32'd0);
        busy_len = 5;
        send_cmd(2'd2, 16'h0020, 6'd2);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_addr = 16'h6000; bus.cmd_len = 6'd1;
        for (int i = 0; i < 10; i++) begin
            bus.rx_valid = (i % 2 == 0);
            bus.rx_byte  = 8'hEE;
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.rx_valid  = 1'b0;
        wait_done(d0, 200);
        repeat (5) step();
        check("busy_cmd_done", 32'(done_cnt - d0), 32'd1);
        check("busy_cmd_nwr", 32'(wr_q.size() - w0), 32'd0);
        check("busy_cmd_ntx", 32'(tx_q.size() - t0), 32'd2);
        if (tx_q.size() >= t0 + 2) check("busy_cmd_tx", 32'({tx_q[t0], tx_q[t0+1]}), 32'h1122);

        // randomized commands against a transaction-level model
        for (int it = 0; it < 40; it++) begin
            op  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            len = 6'($urandom_range(0, 5));
            busy_len = $urandom_range(0, 4);
            for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
            w0 = wr_q.size(); r0 = rd_q.size(); t0 = tx_q.size(); e0 = ex_q.size(); d0 = done_cnt;
            send_cmd(op, a, len);
            if (op == 2'd1) begin
                for (int i = 0; i < int'(len); i++) send_rx(rb[i]);
                if ($urandom_range(0, 1) == 1) send_rx(rb[7]);
            end
            wait_done(d0, 400);
            step(); step(); step();
            check($sformatf("r%0d_done", it), 32'(done_cnt - d0), 32'd1);
            check($sformatf("r%0d_nwr", it), 32'(wr_q.size() - w0), (op == 2'd1) ? 32'(len) : 32'd0);
            check($sformatf("r%0d_ntx", it), 32'(tx_q.size() - t0), (op == 2'd2) ? 32'(len) : 32'd0);
            check($sformatf("r%0d_nrd", it), 32'(rd_q.size() - r0), (op == 2'd2) ? 32'(len) : 32'd0);
            check($sformatf("r%0d_nex", it), 32'(ex_q.size() - e0), (op == 2'd3) ? 32'd1 : 32'd0);
            for (int i = 0; i < int'(len); i++) begin
                ai = a + 16'(i);
                if (op == 2'd1 && w0 + i < wr_q.size())
                    check($sformatf("r%0d_wr%0d", it, i), 32'(wr_q[w0+i]), 32'({ai, rb[i]}));
                if (op == 2'd2 && r0 + i < rd_q.size())
                    check($sformatf("r%0d_rd%0d", it, i), 32'(rd_q[r0+i]), 32'(ai));
                if (op == 2'd2 && t0 + i < tx_q.size())
                    check($sformatf("r%0d_tx%0d", it, i), 32'(tx_q[t0+i]), 32'(mem[ai]));
            end
            if (op == 2'd3 && ex_q.size() > e0)
                check($sformatf("r%0d_exaddr", it), 32'(ex_q[e0]), 32'(a));
        end

        step();
        check("protocol_violations", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
